// File: rtl/md_sched_pkg.sv
// Shared multiply-divide definitions: op codes, op-class decode helpers, scheduler state encoding
// and the queued command record. Used by the MD unit, the decoder and md_sched.
package md_sched_pkg;

    localparam int OP_W    = 4;
    localparam int DATA_W  = 32;
    localparam int ENTRY_W = OP_W + 2 * DATA_W;

    localparam logic [OP_W-1:0] OP_NONE  = 4'd0;
    localparam logic [OP_W-1:0] OP_MULT  = 4'd1;
    localparam logic [OP_W-1:0] OP_MULTU = 4'd2;
    localparam logic [OP_W-1:0] OP_DIV   = 4'd3;
    localparam logic [OP_W-1:0] OP_DIVU  = 4'd4;
    localparam logic [OP_W-1:0] OP_MFHI  = 4'd5;
    localparam logic [OP_W-1:0] OP_MFLO  = 4'd6;
    localparam logic [OP_W-1:0] OP_MTHI  = 4'd7;
    localparam logic [OP_W-1:0] OP_MTLO  = 4'd8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_BUSY   = 2'd2
    } md_state_e;

    typedef struct packed {
        logic [OP_W-1:0]   op;
        logic [DATA_W-1:0] rs;
        logic [DATA_W-1:0] rt;
    } md_cmd_t;

    // Long ops occupy the MD unit for many cycles and must be waited on.
    function automatic logic is_long_op(input logic [OP_W-1:0] op);
        return (op >= OP_MULT) && (op <= OP_DIVU);
    endfunction

    function automatic logic is_write_op(input logic [OP_W-1:0] op);
        return (op == OP_MTHI) || (op == OP_MTLO);
    endfunction

    function automatic logic is_read_op(input logic [OP_W-1:0] op);
        return (op == OP_MFHI) || (op == OP_MFLO);
    endfunction

endpackage

// File: rtl/md_sched_cmd_fifo.sv
// Two-entry in-order command FIFO holding {op, rs, rt} records for md_sched.
// A push while full is accepted only together with a pop in the same cycle.
module md_cmd_fifo
    import md_sched_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               push,
    input  logic [ENTRY_W-1:0] push_data,
    input  logic               pop,
    output logic [ENTRY_W-1:0] pop_data,
    output logic               full,
    output logic               empty,
    output logic [1:0]         count
);

    logic [ENTRY_W-1:0] mem [2];
    logic               wr_ptr;
    logic               rd_ptr;
    logic [1:0]         cnt;
    logic               do_push;
    logic               do_pop;

    assign full     = (cnt == 2'd2);
    assign empty    = (cnt == 2'd0);
    assign count    = cnt;
    assign pop_data = mem[rd_ptr];

    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // One-bit pointers wrap naturally modulo 2.
    always_ff @(posedge clk) begin
        if (!reset) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            cnt    <= 2'd0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 2'd1;
                2'b01:   cnt <= cnt - 2'd1;
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/md_sched.sv
// Multiply-divide issue scheduler: queues long/write ops, serialises them onto the MD unit and
// gates reads until the unit is quiet. Define MD_SCHED_BYPASS_EN for zero-latency issue when empty.
module md_sched
    import md_sched_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    input  logic [OP_W-1:0]   req_op,
    input  logic [DATA_W-1:0] req_rs,
    input  logic [DATA_W-1:0] req_rt,
    input  logic              md_busy,
    output logic [OP_W-1:0]   md_op,
    output logic [DATA_W-1:0] md_rs,
    output logic [DATA_W-1:0] md_rt,
    output logic              stall,
    output logic [1:0]        occupancy
);

    md_state_e state;
    md_state_e state_next;

    logic    req_long;
    logic    req_write;
    logic    req_read;
    logic    req_queued;
    logic    can_issue;
    logic    fifo_push;
    logic    fifo_pop;
    logic    fifo_full;
    logic    fifo_empty;
    logic    bypass;
    logic    read_go;
    md_cmd_t req_cmd;
    md_cmd_t head;

    assign req_long   = req_valid && is_long_op(req_op);
    assign req_write  = req_valid && is_write_op(req_op);
    assign req_read   = req_valid && is_read_op(req_op);
    assign req_queued = req_long || req_write;
    assign can_issue  = (state == ST_IDLE) && !md_busy;
    assign req_cmd    = '{op: req_op, rs: req_rs, rt: req_rt};

    md_cmd_fifo u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (fifo_push),
        .push_data (req_cmd),
        .pop       (fifo_pop),
        .pop_data  (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (occupancy)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Issue priority: queued head first, then a bypassed request, then a read. Stall is derived
    // from acceptance conditions only, never from the command being driven out.
    always_comb begin
        fifo_pop   = 1'b0;
        fifo_push  = 1'b0;
        bypass     = 1'b0;
        read_go    = 1'b0;
        stall      = 1'b0;
        md_op      = OP_NONE;
        md_rs      = '0;
        md_rt      = '0;
        state_next = state;

        if (reset) begin
            fifo_pop = can_issue && !fifo_empty;
`ifdef MD_SCHED_BYPASS_EN
            bypass   = can_issue && fifo_empty && req_queued;
`else
            bypass   = 1'b0;
`endif
            read_go   = req_read && can_issue && fifo_empty;
            fifo_push = req_queued && !bypass && (!fifo_full || fifo_pop);
            stall     = (req_read && !read_go) || (req_queued && fifo_full && !fifo_pop);

            if (fifo_pop) begin
                md_op = head.op;
                md_rs = head.rs;
                md_rt = head.rt;
            end else if (bypass) begin
                md_op = req_op;
                md_rs = req_rs;
                md_rt = req_rt;
            end else if (read_go) begin
                md_op = req_op;
            end
        end

        // Write ops complete in one edge, so only a long op moves the FSM out of IDLE.
        case (state)
            ST_IDLE: begin
                if ((fifo_pop && is_long_op(head.op)) || (bypass && req_long)) begin
                    state_next = ST_LAUNCH;
                end
            end
            ST_LAUNCH: state_next = ST_BUSY;
            ST_BUSY: begin
                if (!md_busy) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_md_sched.sv
// Self-checking bench for md_sched: directed vectors, a queue-based reference model checked every
// cycle, and literal spot checks. Expectations follow MD_SCHED_BYPASS_EN when it is defined.
module tb_md_sched;
    import md_sched_pkg::*;

`ifdef MD_SCHED_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic [3:0]  req_op;
    logic [31:0] req_rs;
    logic [31:0] req_rt;
    logic        md_busy;
    logic [3:0]  md_op;
    logic [31:0] md_rs;
    logic [31:0] md_rt;
    logic        stall;
    logic [1:0]  occupancy;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    md_sched dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_op    (req_op),
        .req_rs    (req_rs),
        .req_rt    (req_rt),
        .md_busy   (md_busy),
        .md_op     (md_op),
        .md_rs     (md_rs),
        .md_rt     (md_rt),
        .stall     (stall),
        .occupancy (occupancy)
    );

    task automatic cmp(input string nm, input logic [67:0] act, input logic [67:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Reference model: pending commands in a queue, plus a count of cycles since the last long op
    // was handed over (0 = scheduler free to issue).
    logic [67:0] cmdQ[$];
    int          sinceLong  = 0;
    bit          modelValid = 0;
    logic [67:0] expCmd;
    bit          expPop;
    bit          expPush;
    bit          expLong;

    always @(negedge clk) begin
        bit free;
        bit queued;
        bit isRead;
        bit bypassOk;
        bit readServed;
        bit expStall;
        if (reset === 1'b0) begin
            expPop  = 0;
            expPush = 0;
            expLong = 0;
            cmp("reset_md_cmd", {md_op, md_rs, md_rt}, 68'd0);
            cmp("reset_stall", 68'(stall), 68'd0);
        end else if (modelValid) begin
            free       = (sinceLong == 0) && !md_busy;
            queued     = req_valid && (req_op inside {[4'd1:4'd4], 4'd7, 4'd8});
            isRead     = req_valid && (req_op inside {4'd5, 4'd6});
            expCmd     = 68'd0;
            expPop     = 0;
            bypassOk   = 0;
            readServed = 0;
            if (free && cmdQ.size() > 0) begin
                expCmd = cmdQ[0];
                expPop = 1;
            end else if (free && queued && BYPASS) begin
                expCmd   = {req_op, req_rs, req_rt};
                bypassOk = 1;
            end else if (free && isRead) begin
                expCmd     = {req_op, 64'd0};
                readServed = 1;
            end
            expPush  = queued && !bypassOk && (cmdQ.size() < 2 || expPop);
            expStall = (isRead && !readServed) || (queued && !bypassOk && !expPush);
            expLong  = (expCmd[67:64] inside {[4'd1:4'd4]});
            cmp("md_cmd", {md_op, md_rs, md_rt}, expCmd);
            cmp("stall", 68'(stall), 68'(expStall));
            cmp("occupancy", 68'(occupancy), 68'(cmdQ.size()));
        end
    end

    always @(posedge clk) begin
        if (reset === 1'b0) begin
            cmdQ.delete();
            sinceLong  = 0;
            modelValid = 1;
        end else if (modelValid) begin
            if (sinceLong > 0) begin
                if (sinceLong >= 2 && !md_busy) sinceLong = 0;
                else sinceLong++;
            end else if (expLong) begin
                sinceLong = 1;
            end
            if (expPop) void'(cmdQ.pop_front());
            if (expPush) cmdQ.push_back({req_op, req_rs, req_rt});
        end
    end

    // Drive one cycle of inputs just after the rising edge, then wait for outputs to settle.
    task automatic applyStimulus(input logic rst, input logic v, input logic [3:0] op,
                                 input logic [31:0] rs, input logic [31:0] rt, input logic busy);
        @(posedge clk);
        #1;
        reset     = rst;
        req_valid = v;
        req_op    = op;
        req_rs    = rs;
        req_rt    = rt;
        md_busy   = busy;
        @(negedge clk);
    endtask

    task automatic checkOutput(input string nm, input logic [67:0] cmd, input logic st,
                               input logic [1:0] occ);
        cmp({nm, "_cmd"}, {md_op, md_rs, md_rt}, cmd);
        cmp({nm, "_stall"}, 68'(stall), 68'(st));
        cmp({nm, "_occ"}, 68'(occupancy), 68'(occ));
    endtask

    initial begin
        reset     = 1'b0;
        req_valid = 1'b0;
        req_op    = OP_NONE;
        req_rs    = '0;
        req_rt    = '0;
        md_busy   = 1'b0;

        applyStimulus(0, 1, OP_MULT, 32'd1, 32'd1, 0);
        applyStimulus(0, 1, OP_MFLO, 32'd0, 32'd0, 0);
        cmp("lit_reset_md_op", 68'(md_op), 68'd0);
        cmp("lit_reset_stall", 68'(stall), 68'd0);
        applyStimulus(1, 0, OP_NONE, 32'd0, 32'd0, 0);
        checkOutput("lit_after_reset", 68'd0, 0, 2'd0);

        // mult into an idle block, then mflo waits for the unit to fall quiet
        applyStimulus(1, 1, OP_MULT, 32'd3, 32'd5, 0);
`ifdef MD_SCHED_BYPASS_EN
        checkOutput("lit_mult_bypass", {OP_MULT, 32'd3, 32'd5}, 0, 2'd0);
        applyStimulus(1, 0, OP_NONE, 32'd0, 32'd0, 0);
        checkOutput("lit_launch", 68'd0, 0, 2'd0);
`else
        checkOutput("lit_mult_queued", 68'd0, 0, 2'd0);
        applyStimulus(1, 0, OP_NONE, 32'd0, 32'd0, 0);
        checkOutput("lit_mult_issue", {OP_MULT, 32'd3, 32'd5}, 0, 2'd1);
`endif
        applyStimulus(1, 1, OP_MFLO, 32'd0, 32'd0, 1);
        checkOutput("lit_mflo_wait", 68'd0, 1, 2'd0);
        applyStimulus(1, 1, OP_MFLO, 32'd0, 32'd0, 1);
        applyStimulus(1, 1, OP_MFLO, 32'd0, 32'd0, 1);
        applyStimulus(1, 1, OP_MFLO, 32'd0, 32'd0, 0);
        checkOutput("lit_mflo_busy_state", 68'd0, 1, 2'd0);
        applyStimulus(1, 1, OP_MFLO, 32'd0, 32'd0, 0);
        checkOutput("lit_mflo_go", {OP_MFLO, 64'd0}, 0, 2'd0);

        // div, mthi, mtlo while the unit is busy; third stalls, then simultaneous pop/push at full
        applyStimulus(1, 1, OP_DIV, 32'd100, 32'd7, 1);
        applyStimulus(1, 1, OP_MTHI, 32'd7, 32'd0, 1);
        applyStimulus(1, 1, OP_MTLO, 32'd9, 32'd0, 1);
        checkOutput("lit_full_stall", 68'd0, 1, 2'd2);
        applyStimulus(1, 1, OP_MTLO, 32'd9, 32'd0, 0);
        checkOutput("lit_pop_push_full", {OP_DIV, 32'd100, 32'd7}, 0, 2'd2);
        applyStimulus(1, 0, OP_NONE, 32'd0, 32'd0, 1);
        applyStimulus(1, 0, OP_NONE, 32'd0, 32'd0, 1);
        applyStimulus(1, 0, OP_NONE, 32'd0, 32'd0, 0);
        checkOutput("lit_div_busy_end", 68'd0, 0, 2'd2);
        applyStimulus(1, 0, OP_NONE, 32'd0, 32'd0, 0);
        checkOutput("lit_mthi_issue", {OP_MTHI, 32'd7, 32'd0}, 0, 2'd2);
        applyStimulus(1, 0, OP_NONE, 32'd0, 32'd0, 0);
        checkOutput("lit_mtlo_issue", {OP_MTLO, 32'd9, 32'd0}, 0, 2'd1);
        applyStimulus(1, 0, OP_NONE, 32'd0, 32'd0, 0);
        checkOutput("lit_drained", 68'd0, 0, 2'd0);

        // reset while BUSY with two entries queued
        applyStimulus(1, 1, OP_DIV, 32'd10, 32'd2, 1);
        applyStimulus(1, 0, OP_NONE, 32'd0, 32'd0, 0);
        applyStimulus(1, 1, OP_MULT, 32'd4, 32'd4, 1);
        applyStimulus(1, 1, OP_MULTU, 32'd5, 32'd5, 1);
        applyStimulus(1, 0, OP_NONE, 32'd0, 32'd0, 1);
        checkOutput("lit_busy_two_queued", 68'd0, 0, 2'd2);
        applyStimulus(0, 1, OP_MULT, 32'd8, 32'd8, 1);
        cmp("lit_mid_reset_md_op", 68'(md_op), 68'd0);
        applyStimulus(1, 0, OP_NONE, 32'd0, 32'd0, 0);
        checkOutput("lit_post_reset", 68'd0, 0, 2'd0);
        applyStimulus(1, 0, OP_NONE, 32'd0, 32'd0, 0);
        checkOutput("lit_post_reset_quiet", 68'd0, 0, 2'd0);

        // fresh traffic after reset, ignored op codes, and a lone write op
        applyStimulus(1, 1, OP_MULTU, 32'd6, 32'd6, 0);
        applyStimulus(1, 0, OP_NONE, 32'd0, 32'd0, 0);
        applyStimulus(1, 1, 4'd12, 32'd1, 32'd2, 1);
        checkOutput("lit_ignored_op", 68'd0, 0, 2'd0);
        applyStimulus(1, 1, OP_NONE, 32'd1, 32'd2, 1);
        applyStimulus(1, 0, OP_NONE, 32'd0, 32'd0, 0);
        applyStimulus(1, 0, OP_NONE, 32'd0, 32'd0, 0);
        applyStimulus(1, 1, OP_MTHI, 32'd11, 32'd0, 0);
        applyStimulus(1, 1, OP_MFHI, 32'd0, 32'd0, 0);
        applyStimulus(1, 0, OP_NONE, 32'd0, 32'd0, 0);
        applyStimulus(1, 0, OP_NONE, 32'd0, 32'd0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/md_sched.md
MD_SCHED -- requirements
Module: md_sched

Interface
REQ-001 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port reset  input  1  synchronous, active-low reset; reset==0 at a rising edge resets the block.
REQ-003 SHALL have port req_valid  input  1  decode stage presents an MD instruction this cycle.
REQ-004 SHALL have port req_op  input  4  op code: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mfhi, 6 mflo, 7 mthi, 8 mtlo.
REQ-005 SHALL have ports req_rs, req_rt  input  32 each  operand values accompanying req_op.
REQ-006 SHALL have port md_busy  input  1  busy flag from the multiply-divide unit.
REQ-007 SHALL have ports md_op (4), md_rs (32), md_rt (32)  output  command presented to the multiply-divide unit.
REQ-008 SHALL have port stall  output  1  request not accepted this cycle; the pipeline holds req_*.
REQ-009 SHALL have port occupancy  output  2  current queue entry count, 0..2.

Function
REQ-010 Ops 1-4 SHALL be "long" ops, ops 7-8 SHALL be "write" ops, and ops 5-6 SHALL be "read" ops; op 0 or values above 8 with req_valid SHALL be ignored with stall=0.
REQ-011 Long and write ops SHALL be held in a 2-entry in-order FIFO of {op, rs, rt}; issue order SHALL equal acceptance order.
REQ-012 The FSM SHALL have states IDLE, LAUNCH, and BUSY.
REQ-013 IDLE->LAUNCH SHALL occur on issue of a long op; LAUNCH->BUSY SHALL be unconditional; BUSY->IDLE SHALL occur when md_busy==0.
REQ-014 Issue of a write op SHALL leave the FSM in IDLE, because the write completes in one edge.
REQ-015 The FIFO head SHALL be issued (popped) only in IDLE with md_busy==0; md_op/md_rs/md_rt SHALL carry the head combinationally that cycle, otherwise md_op=0.
REQ-016 A read op SHALL be driven straight to md_op (rs/rt=0) only when the FIFO is empty, the FSM is IDLE, and md_busy==0; otherwise stall=1 and md_op=0.
REQ-017 A long/write request SHALL stall only when the FIFO is full and no pop occurs that cycle.
REQ-018 Simultaneous push and pop with the FIFO full SHALL be accepted, and occupancy SHALL stay 2.
REQ-019 A push to an empty FIFO in a non-bypass cycle SHALL become issuable no earlier than the next cycle.
REQ-020 stall SHALL be combinational from req_*, FSM state, occupancy, and md_busy; it SHALL never depend on the same-cycle md_op output.
REQ-021 occupancy SHALL never exceed 2 and SHALL never underflow, and FIFO pointers SHALL wrap modulo 2.

Reset
REQ-022 On reset: FSM=IDLE, FIFO empty (occupancy=0), pointers=0, stored entries=0.
REQ-023 While reset==0, md_op SHALL be 0, md_rs/md_rt SHALL be 0, and stall SHALL be 0.
REQ-024 Reset asserted mid-operation (LAUNCH/BUSY or non-empty FIFO) SHALL discard all queued ops without issuing them; resetting the MD unit itself is the system's responsibility.

Configuration
REQ-025 Macro MD_SCHED_BYPASS_EN defined: with the FIFO empty, the FSM IDLE, and md_busy==0, an incoming long/write op SHALL issue the same cycle without a push (zero-latency).
REQ-026 Macro MD_SCHED_BYPASS_EN absent: every long/write op SHALL be pushed first, with minimum issue latency 1 cycle; all other rules are unchanged.

Structure
REQ-027 The op-code constants (0-8), the op-class decode helpers, and the FSM state encoding SHALL live in the shared MD package used by the MD unit and the decoder.
REQ-028 The 2-entry FIFO SHALL be one sub-module, md_cmd_fifo (push/pop/full/empty/count, 68-bit entry); the FSM and issue logic SHALL reside in md_sched.

Verification
REQ-029 The bench SHALL cover, with bypass on: mult rs=3 rt=5 into an idle block -> md_op=1 the same cycle, LAUNCH then BUSY; then mflo -> stall until md_busy falls, then md_op=6.
REQ-030 The bench SHALL cover: div, mthi 7, and mtlo 9 back-to-back while busy -> third request stalls; the entries issue in order div, mthi, mtlo with occupancy sequence 2, 2, 1, 0.
REQ-031 The bench SHALL cover: FIFO full, and the head pops in the same cycle as a new push -> stall=0, occupancy stays 2.
REQ-032 The bench SHALL cover, with bypass off: mult into an empty idle block -> md_op=0 that cycle and md_op=1 the next, occupancy 1 then 0.
REQ-033 The bench SHALL cover: reset driven low while in BUSY with 2 queued entries -> next cycle occupancy=0, FSM IDLE, and md_op=0 thereafter until a new request.
